mux_nch_rr: RTL and testbench

//  Parametrised N-channel, WIDTH-bit multiplexer with a registered, handshaked output.

---
 rtl/mux_nch_rr.sv | 97 +++++++++
 tb/tb_mux_nch_rr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nch_rr.sv
// N-channel WIDTH-bit mux, fixed or round-robin select, registered output one cycle after acceptance.
// Output beat is held stable while out_ready is low; no in_ready is raised until the beat can move.
module mux_nch_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sel_mode,
    input  logic [SEL_W-1:0]        sel_fix,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] gnt;
    logic             gnt_v;
    logic             load;
    int               idx;

    // Grant: fixed channel, or first valid channel scanning upward from ptr_q.
    always_comb begin
        gnt   = '0;
        gnt_v = 1'b0;
        idx   = 0;
        if (!sel_mode) begin
            if (int'(sel_fix) < N_CH) begin
                gnt   = sel_fix;
                gnt_v = in_valid[sel_fix];
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                idx = (int'(ptr_q) + k) % N_CH;
                if (!gnt_v && in_valid[idx]) begin
                    gnt   = SEL_W'(idx);
                    gnt_v = 1'b1;
                end
            end
        end
    end

    // rst_n gates load so no producer sees a handshake while reset is held.
    assign load = rst_n & en & gnt_v & (~out_valid_q | out_ready);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = load && (gnt == SEL_W'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_data_d  = in_data[int'(gnt)*WIDTH +: WIDTH];
            out_ch_d    = gnt;
            out_valid_d = 1'b1;
            if (sel_mode) begin
                ptr_d = (int'(gnt) == N_CH-1) ? '0 : gnt + SEL_W'(1);
            end
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nch_rr.sv
// Bench for mux_nch_rr: literal vector table, hand sequences, fixed-mode sweep and random traffic
// checked against a distance-based round-robin reference model.
module tb_mux_nch_rr;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n, en, sel_mode, out_ready;
    logic [1:0]   sel_fix;
    logic [31:0]  in_data;
    logic [3:0]   in_valid, in_ready;
    logic [7:0]   out_data;
    logic [1:0]   out_ch;
    logic         out_valid;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit       m_vld;
    bit [7:0] m_dat;
    int       m_ch;
    int       m_ptr;
    logic [3:0] last_rdy;

    mux_nch_rr #(.N_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_mode(sel_mode), .sel_fix(sel_fix),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       mode;
        bit [1:0] fix;
        bit [3:0] vld;
        bit [3:0] exp_rdy;
        bit       exp_ovld;
        bit [7:0] exp_odat;
        bit [1:0] exp_och;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Grant = valid channel at the smallest forward distance from the pointer.
    function automatic void m_pick(output int g, output bit gv);
        int best;
        g = 0;
        gv = 1'b0;
        best = N;
        if (!sel_mode) begin
            g  = int'(sel_fix);
            gv = in_valid[sel_fix];
        end else begin
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && ((i - m_ptr + N) % N) < best) begin
                    best = (i - m_ptr + N) % N;
                    g    = i;
                    gv   = 1'b1;
                end
            end
        end
    endfunction

    // One clock: inputs already applied just after the previous edge.
    task automatic cyc(input string nm);
        int g;
        bit gv, ld;
        logic [3:0] er;
        #3;
        m_pick(g, gv);
        ld = rst_n && en && gv && (!m_vld || out_ready);
        er = ld ? 4'(1 << g) : 4'b0;
        last_rdy = in_ready;
        chk({nm, "_rdy"}, in_ready, er);
        if (!rst_n) begin
            m_vld = 0; m_dat = 0; m_ch = 0; m_ptr = 0;
        end else if (ld) begin
            m_dat = in_data[g*8 +: 8];
            m_ch  = g;
            m_vld = 1;
            if (sel_mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
        chk({nm, "_ovld"}, out_valid, m_vld);
        chk({nm, "_odat"}, out_data, m_dat);
        chk({nm, "_och"}, out_ch, m_ch);
    endtask

    initial begin
        vt[0]  = '{0, 2, 4'b0100, 4'b0100, 1, 8'hA5, 2};
        vt[1]  = '{0, 1, 4'b1101, 4'b0000, 0, 8'hA5, 2};
        vt[2]  = '{0, 3, 4'b1101, 4'b1000, 1, 8'h13, 3};
        vt[3]  = '{0, 0, 4'b0000, 4'b0000, 0, 8'h13, 3};
        vt[4]  = '{1, 0, 4'b1010, 4'b0010, 1, 8'h11, 1};
        vt[5]  = '{1, 0, 4'b1010, 4'b1000, 1, 8'h13, 3};
        vt[6]  = '{1, 0, 4'b1010, 4'b0010, 1, 8'h11, 1};
        vt[7]  = '{1, 0, 4'b1010, 4'b1000, 1, 8'h13, 3};
        vt[8]  = '{1, 0, 4'b1111, 4'b0001, 1, 8'h10, 0};
        vt[9]  = '{0, 2, 4'b1111, 4'b0100, 1, 8'hA5, 2};
        vt[10] = '{1, 0, 4'b1111, 4'b0010, 1, 8'h11, 1};
        vt[11] = '{1, 0, 4'b0001, 4'b0001, 1, 8'h10, 0};
        vt[12] = '{1, 0, 4'b0001, 4'b0001, 1, 8'h10, 0};

        rst_n = 0; en = 1; sel_mode = 0; sel_fix = 0; in_data = 0; in_valid = 0; out_ready = 1;
        m_vld = 0; m_dat = 0; m_ch = 0; m_ptr = 0;
        cyc("reset");
        rst_n = 1;

        // Literal vectors, ch0..3 data = 10,11,A5,13
        in_data = {8'h13, 8'hA5, 8'h11, 8'h10};
        for (int i = 0; i < 13; i++) begin
            sel_mode = vt[i].mode; sel_fix = vt[i].fix; in_valid = vt[i].vld;
            cyc($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_rdy", i), last_rdy, vt[i].exp_rdy);
            chk($sformatf("vec%0d_tbl_ovld", i), out_valid, vt[i].exp_ovld);
            chk($sformatf("vec%0d_tbl_odat", i), out_data, vt[i].exp_odat);
            chk($sformatf("vec%0d_tbl_och", i), out_ch, vt[i].exp_och);
        end

        // RR scan of all four channels from a fresh pointer
        rst_n = 0; cyc("rr_rst"); rst_n = 1;
        sel_mode = 1; in_valid = 4'b1111; in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("rr%0d", i));
            chk($sformatf("rr%0d_seq_ch", i), out_ch, i % 4);
            chk($sformatf("rr%0d_seq_dat", i), out_data, 8'h10 + (i % 4));
        end

        // Backpressure: hold 3C for three stalled cycles, then load with no gap
        sel_mode = 0; sel_fix = 0; in_valid = 4'b0001; in_data = {8'h13, 8'h12, 8'h77, 8'h3C};
        cyc("bp_load");
        out_ready = 0; in_valid = 4'b1111; sel_fix = 1;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("bp_hold%0d", i));
            chk($sformatf("bp_hold%0d_rdy0", i), last_rdy, 4'b0000);
            chk($sformatf("bp_hold%0d_dat", i), out_data, 8'h3C);
            chk($sformatf("bp_hold%0d_vld", i), out_valid, 1'b1);
        end
        out_ready = 1;
        cyc("bp_release");
        chk("bp_release_rdy", last_rdy, 4'b0010);
        chk("bp_next_dat", out_data, 8'h77);

        // Reset mid-transfer with pointer moved off zero
        sel_mode = 1; in_valid = 4'b1111; in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        cyc("mid_pre");
        out_ready = 0;
        rst_n = 0;
        cyc("mid_rst");
        chk("mid_rst_rdy0", last_rdy, 4'b0000);
        chk("mid_rst_vld0", out_valid, 1'b0);
        rst_n = 1; out_ready = 1;
        cyc("mid_after");
        chk("mid_after_ptr0_ch", out_ch, 2'd0);

        // en=0: no grants, held beat drains
        en = 0;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("en0_%0d", i));
            chk($sformatf("en0_%0d_rdy0", i), last_rdy, 4'b0000);
        end
        chk("en0_drained", out_valid, 1'b0);
        en = 1;

        // Exhaustive fixed-mode sweep
        sel_mode = 0; in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        for (int f = 0; f < 4; f++) begin
            for (int v = 0; v < 16; v++) begin
                sel_fix = 2'(f); in_valid = 4'(v);
                cyc($sformatf("sweep_f%0d_v%0d", f, v));
            end
        end

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            en        = ($urandom_range(0, 7) != 0);
            sel_mode  = 1'($urandom_range(0, 1));
            sel_fix   = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cyc($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
